// File: rtl/axi_xbar_cfg_pkg.sv
// Shared types and helpers for the AXI crossbar run-time configuration controller.
// Optional drain timeout is enabled with `define AXI_XBAR_CFG_TIMEOUT_EN.
package axi_xbar_cfg_pkg;

    // Address rule layout matching the crossbar's 64-bit rule type.
    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        COMMIT
    } cfg_state_e;

    // Bits needed to hold 0..max_trans inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_trans);
        return unsigned'($clog2(max_trans + 1));
    endfunction

endpackage

// File: rtl/axi_xbar_cfg_if.sv
// Slave-port Ax handshake and response-monitor wires passing through the config controller.
interface axi_xbar_cfg_if #(
    parameter int unsigned NoSlvPorts = 2
);
    logic [NoSlvPorts-1:0] slv_aw_valid_i;
    logic [NoSlvPorts-1:0] slv_aw_valid_o;
    logic [NoSlvPorts-1:0] slv_aw_ready_i;
    logic [NoSlvPorts-1:0] slv_aw_ready_o;
    logic [NoSlvPorts-1:0] slv_ar_valid_i;
    logic [NoSlvPorts-1:0] slv_ar_valid_o;
    logic [NoSlvPorts-1:0] slv_ar_ready_i;
    logic [NoSlvPorts-1:0] slv_ar_ready_o;
    logic [NoSlvPorts-1:0] slv_b_valid_i;
    logic [NoSlvPorts-1:0] slv_b_ready_i;
    logic [NoSlvPorts-1:0] slv_r_valid_i;
    logic [NoSlvPorts-1:0] slv_r_ready_i;
    logic [NoSlvPorts-1:0] slv_r_last_i;

    modport slave (
        input  slv_aw_valid_i, slv_aw_ready_i, slv_ar_valid_i, slv_ar_ready_i,
        input  slv_b_valid_i, slv_b_ready_i, slv_r_valid_i, slv_r_ready_i, slv_r_last_i,
        output slv_aw_valid_o, slv_aw_ready_o, slv_ar_valid_o, slv_ar_ready_o
    );

    modport master (
        output slv_aw_valid_i, slv_aw_ready_i, slv_ar_valid_i, slv_ar_ready_i,
        output slv_b_valid_i, slv_b_ready_i, slv_r_valid_i, slv_r_ready_i, slv_r_last_i,
        input  slv_aw_valid_o, slv_aw_ready_o, slv_ar_valid_o, slv_ar_ready_o
    );
endinterface

// File: rtl/axi_xbar_cfg_txn_cnt.sv
// Outstanding-transaction up/down counter with full flag and "empty after this cycle" flag.
module axi_xbar_cfg_txn_cnt
    import axi_xbar_cfg_pkg::*;
#(
    parameter int unsigned MaxTrans = 8,
    parameter int unsigned CntW     = cnt_width(MaxTrans)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;

    // Simultaneous inc/dec cancel; both ends saturate.
    always_comb begin
        cnt_nxt = cnt;
        if (inc && !dec && (cnt != CntMax)) begin
            cnt_nxt = cnt + CntW'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt_nxt = cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign full = (cnt == CntMax);
    // Zero as seen after this cycle's update, so a drain can finish on the last response.
    assign zero = (cnt_nxt == '0);

    no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && (cnt == '0)));

endmodule

// File: rtl/axi_xbar_cfg_ctrl.sv
// Atomic run-time address-map / default-port updater: blocks Ax, drains, then commits in one cycle.
// Optional drain timeout is enabled with `define AXI_XBAR_CFG_TIMEOUT_EN.
module axi_xbar_cfg_ctrl
    import axi_xbar_cfg_pkg::*;
#(
    parameter int unsigned NoSlvPorts    = 2,
    parameter int unsigned NoMstPorts    = 2,
    parameter int unsigned NoAddrRules   = 2,
    parameter int unsigned MaxTrans      = 8,
    parameter type         rule_t        = xbar_rule_64_t,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned PortW = (NoMstPorts > 1) ? unsigned'($clog2(NoMstPorts)) : 1,
    localparam int unsigned CntW  = cnt_width(MaxTrans)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  rule_t [NoAddrRules-1:0]             rst_map_i,
    input  logic                                cfg_req_i,
    input  rule_t [NoAddrRules-1:0]             cfg_map_i,
    input  logic  [NoSlvPorts-1:0]              cfg_en_def_i,
    input  logic  [NoSlvPorts-1:0][PortW-1:0]   cfg_def_port_i,
    output logic                                cfg_ack_o,
    output logic                                cfg_err_o,
    output rule_t [NoAddrRules-1:0]             addr_map_o,
    output logic  [NoSlvPorts-1:0]              en_default_mst_port_o,
    output logic  [NoSlvPorts-1:0][PortW-1:0]   default_mst_port_o,
    output logic                                busy_o,
    axi_xbar_cfg_if.slave                       bus
);
    if ((TimeoutCycles < 2) || (MaxTrans < 1)) begin : g_param_check
        $error("axi_xbar_cfg_ctrl: TimeoutCycles must be >= 2 and MaxTrans >= 1");
    end

    cfg_state_e state;

    logic [NoSlvPorts-1:0] aw_full, ar_full, wr_zero, rd_zero;
    logic [NoSlvPorts-1:0] aw_block, ar_block;
    logic [NoSlvPorts-1:0] aw_inc, ar_inc, b_dec, r_dec;
    logic                  all_zero;
    logic                  timeout_hit;

    // Blocking depends only on registered state and counters.
    assign aw_block = {NoSlvPorts{state != IDLE}} | aw_full;
    assign ar_block = {NoSlvPorts{state != IDLE}} | ar_full;

    assign bus.slv_aw_valid_o = bus.slv_aw_valid_i & ~aw_block;
    assign bus.slv_aw_ready_o = bus.slv_aw_ready_i & ~aw_block;
    assign bus.slv_ar_valid_o = bus.slv_ar_valid_i & ~ar_block;
    assign bus.slv_ar_ready_o = bus.slv_ar_ready_i & ~ar_block;

    assign aw_inc = bus.slv_aw_valid_i & bus.slv_aw_ready_i & ~aw_block;
    assign ar_inc = bus.slv_ar_valid_i & bus.slv_ar_ready_i & ~ar_block;
    assign b_dec  = bus.slv_b_valid_i & bus.slv_b_ready_i;
    assign r_dec  = bus.slv_r_valid_i & bus.slv_r_ready_i & bus.slv_r_last_i;

    for (genvar i = 0; i < NoSlvPorts; i++) begin : g_port
        axi_xbar_cfg_txn_cnt #(.MaxTrans(MaxTrans), .CntW(CntW)) i_wr_cnt (
            .clk  (clk_i),
            .rst  (rst_i),
            .inc  (aw_inc[i]),
            .dec  (b_dec[i]),
            .full (aw_full[i]),
            .zero (wr_zero[i])
        );
        axi_xbar_cfg_txn_cnt #(.MaxTrans(MaxTrans), .CntW(CntW)) i_rd_cnt (
            .clk  (clk_i),
            .rst  (rst_i),
            .inc  (ar_inc[i]),
            .dec  (r_dec[i]),
            .full (ar_full[i]),
            .zero (rd_zero[i])
        );
    end

    assign all_zero = &{wr_zero, rd_zero};

`ifdef AXI_XBAR_CFG_TIMEOUT_EN
    localparam int unsigned TmoW = cnt_width(TimeoutCycles);

    logic [TmoW-1:0] drain_cycles;

    assign timeout_hit = (state == DRAIN) && !all_zero &&
                         (drain_cycles == TmoW'(TimeoutCycles - 1));

    // Counts DRAIN cycles; abandons the update once the limit is spent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cycles <= '0;
            cfg_err_o    <= 1'b0;
        end else begin
            cfg_err_o <= timeout_hit;
            if ((state == DRAIN) && !timeout_hit) begin
                drain_cycles <= drain_cycles + TmoW'(1);
            end else begin
                drain_cycles <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign cfg_err_o   = 1'b0;
`endif

    // Update sequencer; configuration outputs move only on COMMIT or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state                 <= IDLE;
            busy_o                <= 1'b0;
            cfg_ack_o             <= 1'b0;
            addr_map_o            <= rst_map_i;
            en_default_mst_port_o <= '0;
            default_mst_port_o    <= '0;
        end else begin
            cfg_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_req_i) begin
                        state  <= DRAIN;
                        busy_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (all_zero) begin
                        state     <= COMMIT;
                        cfg_ack_o <= 1'b1;
                    end else if (timeout_hit) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                COMMIT: begin
                    addr_map_o            <= cfg_map_i;
                    en_default_mst_port_o <= cfg_en_def_i;
                    default_mst_port_o    <= cfg_def_port_i;
                    state                 <= IDLE;
                    busy_o                <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_xbar_cfg_ctrl.md
Name: axi_xbar_cfg_ctrl

Overview:
Run-time configuration controller for the AXI crossbar. It owns the crossbar's address map and default-master-port settings, and applies new settings atomically. On an update request it stops new AW/AR acceptance on every slave port, waits for all outstanding transactions to complete, then commits the new configuration in one cycle. It sits between the slave-port handshake wires and the crossbar, so the crossbar never sees a configuration change while an Ax beat is unserved.

Parameters:
NoSlvPorts, 2, number of crossbar slave ports
NoMstPorts, 2, number of crossbar master ports; default-port index width is $clog2(NoMstPorts)
NoAddrRules, 2, number of address rules
MaxTrans, 8, outstanding write (and read) transactions tracked per slave port; counter width is $clog2(MaxTrans+1)
rule_t, axi_pkg::xbar_rule_64_t, address rule type
TimeoutCycles, 1024, drain limit in cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
rst_map_i  in  NoAddrRules x rule_t  address map loaded at reset
cfg_req_i  in  1  update request; held until cfg_ack_o
cfg_map_i  in  NoAddrRules x rule_t  new address map; stable while cfg_req_i is high
cfg_en_def_i  in  NoSlvPorts  new default-port enables
cfg_def_port_i  in  NoSlvPorts x $clog2(NoMstPorts)  new default ports
cfg_ack_o  out  1  one-cycle pulse in the commit cycle
cfg_err_o  out  1  one-cycle pulse when a drain times out (optional feature only)
addr_map_o  out  NoAddrRules x rule_t  to crossbar addr_map_i
en_default_mst_port_o  out  NoSlvPorts  to crossbar
default_mst_port_o  out  NoSlvPorts x $clog2(NoMstPorts)  to crossbar
slv_aw_valid_i / slv_ar_valid_i  in  NoSlvPorts  from upstream masters
slv_aw_valid_o / slv_ar_valid_o  out  NoSlvPorts  gated valids to crossbar
slv_aw_ready_i / slv_ar_ready_i  in  NoSlvPorts  from crossbar
slv_aw_ready_o / slv_ar_ready_o  out  NoSlvPorts  gated readies to upstream masters
slv_b_valid_i, slv_b_ready_i, slv_r_valid_i, slv_r_ready_i, slv_r_last_i  in  NoSlvPorts  monitored response handshakes
busy_o  out  1  high when the state is not IDLE

Behaviour:
- Reset: state IDLE. addr_map_o = rst_map_i. en_default_mst_port_o = 0. default_mst_port_o = 0. All counters = 0. cfg_ack_o = 0, cfg_err_o = 0.
- block = (state != IDLE) or (the port's counter == MaxTrans), evaluated per port and per channel. block is derived from registered state and counters; it has no combinational path from cfg_req_i.
- Gating: *_valid_o = valid_i & ~block and *_ready_o = ready_i & ~block. A blocked Ax stays pending upstream, so it is never accepted and never lost.
- Write counter [i]: +1 on the gated AW handshake, −1 on a B handshake. Read counter [i]: +1 on the gated AR handshake, −1 on an R handshake with r_last. Increment and decrement in the same cycle leave the counter unchanged. A decrement at 0 is a protocol error: assert in simulation, saturate in RTL.
- States:
  - IDLE: on cfg_req_i go to DRAIN. An Ax handshake in that same cycle is still counted.
  - DRAIN: block all ports. When every counter is 0, go to COMMIT.
  - COMMIT: load the outputs from the cfg_* inputs, pulse cfg_ack_o, go to IDLE. New values are visible on the next cycle.
- Latency: with nothing outstanding, cfg_req_i rising at cycle 0 gives DRAIN at cycle 1, COMMIT at cycle 2, new config and unblocking at cycle 3. Minimum 3 cycles.
- If cfg_req_i is still high in the cycle after the ack, a new update starts. The requester drops it on cfg_ack_o.
- Reset mid-DRAIN: immediate return to reset values; in-flight count is lost. Reset of this block and of the crossbar are shared.
- Outputs change only in the COMMIT cycle or on reset.

Optional Feature:
AXI_XBAR_CFG_TIMEOUT_EN:
- Defined: a drain cycle counter runs in DRAIN. After TimeoutCycles cycles with nonzero counters, pulse cfg_err_o, return to IDLE without committing, and keep the old configuration.
- Undefined: DRAIN waits indefinitely and cfg_err_o is tied to 0.

Decomposition:
- Package axi_xbar_cfg_pkg: state enum (IDLE, DRAIN, COMMIT), helper function cnt_width(MaxTrans).
- Sub-module axi_xbar_cfg_txn_cnt: one up/down counter with saturate-at-max flag and zero flag, instantiated 2×NoSlvPorts times.

Test Plan:
- Idle bus, cfg_req_i pulse at cycle 0 with rule0 = [0x0, 0x1000) → port 0 → addr_map_o updates at cycle 3, cfg_ack_o high at cycle 2, busy_o high in cycles 1–2.
- Port 1 has 3 AWs accepted and no Bs; request update → stays in DRAIN, slv_aw_ready_o = 0; send 3 B handshakes → COMMIT 1 cycle after the third B.
- AW handshake in the same cycle as cfg_req_i → counted (write counter = 1); DRAIN lasts until the matching B.
- Port 0 issues 8 reads with no R → slv_ar_ready_o[0] = 0 while port 1 is still accepted; one R with r_last → port 0 accepts again next cycle.
- With AXI_XBAR_CFG_TIMEOUT_EN and TimeoutCycles = 16, one B never returns → cfg_err_o pulses after 16 DRAIN cycles and the outputs keep their old values.
- rst_i asserted during DRAIN → next cycle state IDLE, counters 0, addr_map_o = rst_map_i.
